// File: rtl/pmic_multiphase_pkg.sv
// Shared types and default parameter values for the multiphase buck controller.
package pmic_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_READ1,
    S_READ2,
    S_UPDATE
  } adc_state_e;

  localparam int DEF_PHASES   = 2;
  localparam int DEF_ADC_W    = 8;
  localparam int DEF_PWM_W    = 8;
  localparam int DEF_DEADTIME = 2;
  localparam int DEF_KSHIFT   = 2;
  localparam int DEF_TIMEOUT  = 64;

endpackage

// File: rtl/pmic_multiphase_if.sv
// Parallel ADC bus: conversion start, busy handshake, active-low read strobe and data.
interface pmic_multiphase_if
  import pmic_pkg::*;
#(
  parameter int ADC_W = DEF_ADC_W
);
  logic             conv_start;
  logic             rd_cs;
  logic             busy;
  logic [ADC_W-1:0] adc_data;

  modport master (output conv_start, output rd_cs, input busy, input adc_data);
  modport slave  (input conv_start, input rd_cs, output busy, output adc_data);
endinterface

// File: rtl/pmic_multiphase_deadtime.sv
// One phase gate driver: break-before-make with a restartable dead-time counter.
module pmic_deadtime
  import pmic_pkg::*;
#(
  parameter int DEADTIME = DEF_DEADTIME
) (
  input  logic clk,
  input  logic reset,
  input  logic allow,
  input  logic demand,
  output logic hs,
  output logic ls
);

  localparam logic [3:0] DT_FULL = 4'(DEADTIME);
  localparam logic [3:0] DT_EDGE = 4'(DEADTIME - 1);

  logic [3:0] dt_q, dt_d;
  logic       dem_q, dem_d;
  logic       hs_q, hs_d;
  logic       ls_q, ls_d;
  logic       change;

  // A demand edge reloads one short of DEADTIME: the edge-detect cycle itself is the first off cycle.
  always_comb begin
    change = (demand != dem_q);
    dem_d  = demand;
    dt_d   = dt_q;
    hs_d   = 1'b0;
    ls_d   = 1'b0;
    if (!allow) begin
      dt_d = DT_FULL;
    end else if (change) begin
      dt_d = DT_EDGE;
    end else if (dt_q != 4'd0) begin
      dt_d = dt_q - 4'd1;
    end else begin
      hs_d = dem_q;
      ls_d = !dem_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dt_q  <= DT_FULL;
      dem_q <= 1'b0;
      hs_q  <= 1'b0;
      ls_q  <= 1'b0;
    end else begin
      dt_q  <= dt_d;
      dem_q <= dem_d;
      hs_q  <= hs_d;
      ls_q  <= ls_d;
    end
  end

  assign hs = hs_q;
  assign ls = ls_q;

endmodule

// File: rtl/pmic_multiphase.sv
// Interleaved multiphase buck controller: PWM generation, ADC sampling FSM,
// integrating duty regulation and latched overvoltage protection.
module pmic_multiphase
  import pmic_pkg::*;
#(
  parameter int PHASES   = DEF_PHASES,
  parameter int ADC_W    = DEF_ADC_W,
  parameter int PWM_W    = DEF_PWM_W,
  parameter int DEADTIME = DEF_DEADTIME,
  parameter int KSHIFT   = DEF_KSHIFT,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  pmic_multiphase_if.master adc,
  input  logic [ADC_W-1:0]  target,
  input  logic [ADC_W-1:0]  ov_limit,
  input  logic              fault_clr,
  output logic [PHASES-1:0] hs,
  output logic [PHASES-1:0] ls,
  output logic [PWM_W-1:0]  duty,
  output logic              fault,
  output logic              adc_err,
  output logic              sample_valid
);

  localparam int PSTEP  = (1 << PWM_W) / PHASES;
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam int SUM_W  = ((PWM_W > ADC_W) ? PWM_W : ADC_W + 1) + 2;
  localparam logic signed [SUM_W-1:0] DUTY_MAX = SUM_W'((64'd1 << PWM_W) - 64'd1);

  function automatic logic [PWM_W-1:0] sat_duty(input logic signed [SUM_W-1:0] v);
    if (v < 0) return '0;
    if (v > DUTY_MAX) return '1;
    return v[PWM_W-1:0];
  endfunction

  adc_state_e          state_q, state_d;
  logic [PWM_W-1:0]    cnt_q, cnt_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [ADC_W-1:0]    sample_q, sample_d;
  logic [PWM_W-1:0]    duty_q, duty_d;
  logic                fault_q, fault_d;
  logic                adc_err_q, adc_err_d;
  logic                aborted_q, aborted_d;
  logic                fault_set;
  logic                apply;
  logic signed [ADC_W:0]   err, err_sh;
  logic signed [SUM_W-1:0] sum;
  logic [PHASES-1:0]   demand;
  logic                allow;

  always_comb begin
    err    = $signed({1'b0, target}) - $signed({1'b0, sample_q});
    err_sh = err >>> KSHIFT;
    sum    = SUM_W'($signed({1'b0, duty_q})) + SUM_W'(err_sh);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + PWM_W'(1);
    wcnt_d    = wcnt_q;
    sample_d  = sample_q;
    duty_d    = duty_q;
    fault_d   = fault_q;
    adc_err_d = 1'b0;
    aborted_d = aborted_q | !enable;
    fault_set = 1'b0;
    apply     = 1'b0;
    case (state_q)
      S_IDLE: begin
        aborted_d = 1'b0;
        if (enable && cnt_q == '1) state_d = S_START;
      end
      S_START: begin
        wcnt_d  = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        wcnt_d = wcnt_q + WCNT_W'(1);
        if (!adc.busy && wcnt_q >= WCNT_W'(1)) begin
          state_d = S_READ1;
        end else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
          adc_err_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_READ1: state_d = S_READ2;
      S_READ2: begin
        sample_d = adc.adc_data;
        state_d  = S_UPDATE;
      end
      S_UPDATE: begin
        state_d   = S_IDLE;
        fault_set = (sample_q > ov_limit);
        apply     = !aborted_q && enable;
        // Regulation is frozen while a fault is latched; it resumes from zero after clearing.
        if (fault_set) duty_d = '0;
        else if (apply && !fault_q) duty_d = sat_duty(sum);
      end
      default: state_d = S_IDLE;
    endcase
    if (fault_set) fault_d = 1'b1;
    else if (fault_clr && sample_q <= ov_limit) fault_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      sample_q  <= '0;
      duty_q    <= '0;
      fault_q   <= 1'b0;
      adc_err_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      sample_q  <= sample_d;
      duty_q    <= duty_d;
      fault_q   <= fault_d;
      adc_err_q <= adc_err_d;
      aborted_q <= aborted_d;
    end
  end

  // Strobes decode straight from the state register so reset releases rd_cs without a clock.
  assign adc.conv_start = (state_q == S_START);
  assign adc.rd_cs      = !(state_q == S_READ1 || state_q == S_READ2);
  assign fault          = fault_q | fault_set;
  assign duty           = fault_set ? '0 : duty_q;
  assign adc_err        = adc_err_q;
  assign sample_valid   = apply;
  assign allow          = enable && !fault;

  for (genvar i = 0; i < PHASES; i++) begin : g_phase
    logic [PWM_W-1:0] pcnt;
    assign pcnt      = cnt_q + PWM_W'(i * PSTEP);
    assign demand[i] = (pcnt < duty_q);

    pmic_deadtime #(
      .DEADTIME(DEADTIME)
    ) u_deadtime (
      .clk   (clk),
      .reset (reset),
      .allow (allow),
      .demand(demand[i]),
      .hs    (hs[i]),
      .ls    (ls[i])
    );
  end

endmodule

// File: tb/tb_pmic_multiphase.sv
// Directed bench for pmic_multiphase with a small behavioural ADC on the bus interface.
module tb_pmic_multiphase;
  localparam int PHASES = 2;
  localparam int ADC_W  = 8;
  localparam int PWM_W  = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              fault_clr = 1'b0;
  logic [ADC_W-1:0]  target = '0;
  logic [ADC_W-1:0]  ov_limit = '1;
  logic [PHASES-1:0] hs, ls;
  logic [PWM_W-1:0]  duty;
  logic              fault, adc_err, sample_valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int overlap = 0;
  int busy_len = 3;
  int busy_cnt = 0;
  bit busy_force = 1'b0;
  logic [ADC_W-1:0] adc_value = '0;

  pmic_multiphase_if #(.ADC_W(ADC_W)) bus ();

  pmic_multiphase #(
    .PHASES(PHASES), .ADC_W(ADC_W), .PWM_W(PWM_W),
    .DEADTIME(2), .KSHIFT(2), .TIMEOUT(64)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .adc(bus),
    .target(target), .ov_limit(ov_limit), .fault_clr(fault_clr),
    .hs(hs), .ls(ls), .duty(duty), .fault(fault),
    .adc_err(adc_err), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: busy for busy_len cycles after each start pulse, data always presented.
  always @(negedge clk) begin
    if (bus.conv_start) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    bus.busy = busy_force || (busy_cnt != 0);
    bus.adc_data = adc_value;
    if ((hs & ls) != 0) overlap = overlap + 1;
  end

  task automatic wait_sv(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (sample_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_start(input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (bus.conv_start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.conv_start !== 1'b0) begin errors++; $display("FAIL reset_conv_start got %b want 0", bus.conv_start); end
    checks++; if (bus.rd_cs !== 1'b1) begin errors++; $display("FAIL reset_rd_cs got %b want 1", bus.rd_cs); end
    checks++; if (hs !== 2'b00 || ls !== 2'b00) begin errors++; $display("FAIL reset_gates got hs=%b ls=%b want 00", hs, ls); end
    checks++; if (duty !== 8'd0) begin errors++; $display("FAIL reset_duty got %0d want 0", duty); end
    checks++; if (fault !== 1'b0 || adc_err !== 1'b0 || sample_valid !== 1'b0) begin
      errors++; $display("FAIL reset_flags got fault=%b adc_err=%b sv=%b want 000", fault, adc_err, sample_valid); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_regulation;
    bit ok;
    int last;
    last = 0;
    target = 8'd128; ov_limit = 8'd255; adc_value = 8'd96; enable = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      wait_sv(600, ok);
      checks++; if (!ok) begin errors++; $display("FAIL reg_sample_%0d got timeout want sample_valid", k); end
      if (k > 1) begin
        checks++; if (cyc - last != 256) begin errors++; $display("FAIL reg_period_%0d got %0d want 256", k, cyc - last); end
      end
      last = cyc;
      @(negedge clk);
      checks++; if (duty !== 8'(8 * k)) begin errors++; $display("FAIL reg_duty_%0d got %0d want %0d", k, duty, 8 * k); end
    end
  endtask

  task automatic test_interleave;
    bit ok, prev;
    int run, t0, off_rise, off_fall;
    adc_value = 8'd192;
    wait_sv(600, ok);
    @(negedge clk);
    checks++; if (duty !== 8'd64) begin errors++; $display("FAIL ilv_duty got %0d want 64", duty); end
    adc_value = 8'd128;
    ok = 1'b0; prev = hs[0]; run = 0; t0 = 0; off_rise = -1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (hs[0] && !prev) begin ok = 1'b1; t0 = cyc; off_rise = run; break; end
      prev = hs[0];
      if (!hs[0] && !ls[0]) run++; else run = 0;
    end
    checks++; if (!ok || off_rise != 2) begin errors++; $display("FAIL ilv_deadtime_rise got %0d want 2", off_rise); end
    ok = 1'b0; prev = hs[1]; run = 0; off_fall = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!hs[0] && !ls[0]) run++;
      else if (ls[0] && off_fall < 0) off_fall = run;
      else run = 0;
      if (hs[1] && !prev) begin ok = 1'b1; break; end
      prev = hs[1];
    end
    checks++; if (!ok || cyc - t0 != 128) begin errors++; $display("FAIL ilv_phase_offset got %0d want 128", cyc - t0); end
    checks++; if (off_fall != 2) begin errors++; $display("FAIL ilv_deadtime_fall got %0d want 2", off_fall); end
  endtask

  task automatic test_enable_drop;
    bit ok;
    int sv_seen;
    logic [PWM_W-1:0] d0;
    wait_start(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL endrop_start got timeout want conv_start"); end
    enable = 1'b0; d0 = duty; sv_seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (sample_valid) sv_seen++;
    end
    checks++; if (sv_seen != 0) begin errors++; $display("FAIL endrop_sv got %0d want 0", sv_seen); end
    checks++; if (duty !== d0) begin errors++; $display("FAIL endrop_duty got %0d want %0d", duty, d0); end
    checks++; if (hs !== 2'b00 || ls !== 2'b00) begin errors++; $display("FAIL endrop_gates got hs=%b ls=%b want 00", hs, ls); end
    enable = 1'b1;
  endtask

  task automatic test_fault;
    bit ok;
    ov_limit = 8'd180; adc_value = 8'd200;
    ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (fault) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL fault_set got timeout want fault=1"); end
    checks++; if (duty !== 8'd0) begin errors++; $display("FAIL fault_duty got %0d want 0", duty); end
    checks++; if (sample_valid !== 1'b1) begin errors++; $display("FAIL fault_update_cycle got sv=%b want 1", sample_valid); end
    @(negedge clk);
    checks++; if (hs !== 2'b00 || ls !== 2'b00) begin errors++; $display("FAIL fault_gates got hs=%b ls=%b want 00", hs, ls); end
    adc_value = 8'd100;
    wait_sv(600, ok);
    @(negedge clk);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_latched got %b want 1", fault); end
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear got %b want 0", fault); end
    ov_limit = 8'd255;
  endtask

  task automatic test_timeout;
    bit ok, rd_low;
    int n_err;
    logic [PWM_W-1:0] d0;
    busy_force = 1'b1;
    wait_start(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_start got timeout want conv_start"); end
    d0 = duty; rd_low = 1'b0; n_err = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (bus.rd_cs !== 1'b1) rd_low = 1'b1;
      if (adc_err && n_err < 0) n_err = n;
      if (n == n_err + 1 && n_err > 0) begin
        checks++; if (adc_err !== 1'b0) begin errors++; $display("FAIL tmo_pulse_width got %b want 0", adc_err); end
      end
    end
    busy_force = 1'b0;
    checks++; if (n_err != 65) begin errors++; $display("FAIL tmo_latency got %0d want 65", n_err); end
    checks++; if (duty !== d0) begin errors++; $display("FAIL tmo_duty got %0d want %0d", duty, d0); end
    checks++; if (rd_low) begin errors++; $display("FAIL tmo_rd_cs got low want stays 1"); end
  endtask

  task automatic test_async_reset;
    bit ok;
    target = 8'd128; adc_value = 8'd96; enable = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      if (bus.rd_cs === 1'b0) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL areset_read1 got timeout want rd_cs=0"); end
    checks++; if ((hs | ls) === 2'b00) begin errors++; $display("FAIL areset_pre_gates got hs=%b ls=%b want active", hs, ls); end
    #1 reset = 1'b1;
    #1;
    checks++; if (bus.rd_cs !== 1'b1) begin errors++; $display("FAIL areset_rd_cs got %b want 1", bus.rd_cs); end
    checks++; if (hs !== 2'b00 || ls !== 2'b00) begin errors++; $display("FAIL areset_gates got hs=%b ls=%b want 00", hs, ls); end
    checks++; if (duty !== 8'd0) begin errors++; $display("FAIL areset_duty got %0d want 0", duty); end
    @(negedge clk);
    reset = 1'b0;
    wait_sv(600, ok);
    @(negedge clk);
    checks++; if (!ok || duty !== 8'd8) begin errors++; $display("FAIL areset_restart got %0d want 8", duty); end
  endtask

  task automatic test_random;
    bit pending;
    int e, s;
    pending = 1'b0; s = 0;
    ov_limit = 8'd255;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      if (pending) begin
        checks++; if (duty !== 8'(s)) begin errors++; $display("FAIL rand_duty got %0d want %0d", duty, s); end
        pending = 1'b0;
        target = 8'($urandom_range(0, 255));
        adc_value = 8'($urandom_range(0, 255));
      end
      if (sample_valid) begin
        e = (int'(target) - int'(adc_value)) >>> 2;
        s = int'(duty) + e;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        pending = 1'b1;
      end
    end
    checks++; if (overlap != 0) begin errors++; $display("FAIL shoot_through got %0d want 0", overlap); end
  endtask

  initial begin
    test_reset();
    test_regulation();
    test_interleave();
    test_enable_drop();
    test_fault();
    test_timeout();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmic_multiphase.md
PMIC_MULTIPHASE -- requirements
Module: pmic_multiphase

Interface
REQ-001 Parameter PHASES, default 2: number of interleaved buck phases (1..4).
REQ-002 Parameter ADC_W, default 8: ADC parallel data width.
REQ-003 Parameter PWM_W, default 8: PWM counter and duty width; period = 2^PWM_W cycles.
REQ-004 Parameter DEADTIME, default 2: cycles both switches of a phase are off between transitions (1..15).
REQ-005 Parameter KSHIFT, default 2: arithmetic right shift applied to the regulation error.
REQ-006 Parameter TIMEOUT, default 64: maximum cycles spent waiting on ADC busy.
REQ-007 clk  in  1  single system clock, all logic rising-edge.
REQ-008 reset  in  1  asynchronous, active-high reset.
REQ-009 enable  in  1  regulation and switching enable.
REQ-010 busy  in  1  ADC conversion busy, high while converting.
REQ-011 adc_data  in  ADC_W  ADC parallel result.
REQ-012 target  in  ADC_W  regulation setpoint, unsigned.
REQ-013 ov_limit  in  ADC_W  overvoltage threshold, unsigned.
REQ-014 fault_clr  in  1  single-cycle clear of latched fault.
REQ-015 conv_start  out  1  ADC conversion start pulse.
REQ-016 rd_cs  out  1  ADC read/chip-select, active low.
REQ-017 hs  out  PHASES  high-side gate drive per phase.
REQ-018 ls  out  PHASES  low-side (synchronous rectifier) gate drive per phase.
REQ-019 duty  out  PWM_W  current duty command.
REQ-020 fault  out  1  latched overvoltage fault.
REQ-021 adc_err  out  1  one-cycle pulse on busy timeout.
REQ-022 sample_valid  out  1  one-cycle pulse when a new sample has been applied.

Function
REQ-023 Free-running counter cnt, PWM_W bits, wraps from 2^PWM_W-1 to 0; phase i uses pcnt_i = cnt + i*(2^PWM_W/PHASES), modulo 2^PWM_W.
REQ-024 Phase demand d_i = (pcnt_i < duty); duty=0 gives constant low-side, duty=2^PWM_W-1 gives high-side on all but one cycle.
REQ-025 ADC FSM states IDLE, START, WAIT_BUSY, READ1, READ2, UPDATE.
REQ-026 IDLE -> START when enable=1 and cnt=2^PWM_W-1; otherwise remain.
REQ-027 START: conv_start=1 for exactly one cycle, then WAIT_BUSY.
REQ-028 WAIT_BUSY: exit to READ1 when busy=0 and at least 2 cycles have elapsed in state; after TIMEOUT cycles without exit, pulse adc_err, go IDLE, duty unchanged.
REQ-029 READ1 and READ2: rd_cs=0; adc_data captured at the end of READ2; then UPDATE.
REQ-030 UPDATE (one cycle): err = target - sample, signed ADC_W+1 bits; duty <= saturate(duty + (err >>> KSHIFT), 0, 2^PWM_W-1); sample_valid=1; go IDLE.
REQ-031 In UPDATE, if sample > ov_limit, fault sets; duty is forced to 0 the same cycle.
REQ-032 fault stays set until reset or fault_clr=1 with the current sample <= ov_limit; fault set has priority over fault_clr in the same cycle.
REQ-033 enable falling mid-conversion: FSM completes the current sequence, duty not updated, sample_valid not pulsed.
REQ-034 Per phase, if enable=0 or fault=1: hs=ls=0 on the next cycle, no dead time.
REQ-035 Otherwise a change in d_i drives hs_i=ls_i=0 for DEADTIME cycles, then hs_i=d_i, ls_i=!d_i; a demand reversal during dead time restarts the dead-time count.
REQ-036 hs_i and ls_i SHALL never be 1 in the same cycle, under any input sequence.
REQ-037 On enable rising, each phase starts with DEADTIME off cycles before driving either switch.

Reset
REQ-038 Reset values: conv_start=0, rd_cs=1, hs=0, ls=0, duty=0, fault=0, adc_err=0, sample_valid=0, cnt=0, FSM=IDLE, dead-time counters=DEADTIME.
REQ-039 Reset asserted mid-conversion returns the FSM to IDLE and rd_cs to 1 immediately (asynchronously).

Structure
REQ-040 Package pmic_pkg SHALL hold the ADC FSM state enum and the default parameter constants.
REQ-041 Sub-module pmic_deadtime, one instance per phase (inputs clk, reset, allow, demand; outputs hs, ls), implements REQ-034..REQ-037.

Verification
REQ-042 PHASES=2, target=128, ADC returns 96 for 10 samples -> duty rises by 8 per sample to 80; sample_valid once per 256-cycle period.
REQ-043 ADC returns 200 with ov_limit=180 -> fault=1 and duty=0 in the UPDATE cycle, hs=ls=0 the next cycle; fault_clr with sample 100 -> fault=0.
REQ-044 busy held high for 100 cycles -> adc_err pulse after 64 cycles, duty unchanged, rd_cs stays 1.
REQ-045 duty=64, PHASES=2, DEADTIME=2 -> hs rising of phase1 128 cycles after phase0, exactly 2 both-off cycles at each edge, hs&ls never 1.
REQ-046 Reset asserted in READ1 -> rd_cs=1 and all gates 0 without waiting for clk; restart behaves as from power-up.
REQ-047 Randomised target/adc_data for 10k cycles -> duty stays within 0..255 and REQ-036 never violated.
